// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM for a multicycle RISC-V datapath.
// It also decodes ALUControl from funct3 and ImmSrc from the opcode.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_o
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                         MEMWB = 4'd4, MEMWRITE = 4'd5, EXECUTER = 4'd6, EXECUTEI = 4'd7,
                         ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
  logic [3:0] state_q, state_d;
  logic       done_q, done_d, ill_q, ill_d;
  logic [1:0] alu_op;
  logic       branch, pc_update;
  always_comb begin
    state_d   = FETCH;
    ill_d     = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    alu_op    = 2'b00;
    branch    = 1'b0;
    pc_update = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      ill_d   = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        state_d  = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: RegWrite = 1'b1;
      BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end
      default: state_d = FETCH;
    endcase
    // retire on any completing state falling back to FETCH (a stalled MEMWRITE stays put)
    done_d = (state_d == FETCH) &&
             (state_q == MEMWB || state_q == MEMWRITE || state_q == ALUWB || state_q == BEQ);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= FETCH;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
    end
  assign PCWrite    = pc_update | (branch & Zero);
  assign ImmSrc     = (op == OP_SW) ? 2'b01 : (op == OP_BEQ) ? 2'b10 : (op == OP_JAL) ? 2'b11 : 2'b00;
  assign ALUControl = (alu_op == 2'b00) ? 3'b000 :
                      (alu_op == 2'b01) ? 3'b001 :
                      (funct3 == 3'b000) ? {2'b00, op[5] & funct7b5} :
                      (funct3 == 3'b010) ? 3'b101 :
                      (funct3 == 3'b110) ? 3'b011 :
                      (funct3 == 3'b111) ? 3'b010 : 3'b000;
  assign instr_done = done_q;
  assign illegal_op = ill_q;
  assign state_o    = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed vectors with hand-computed expectations.
module tb_multicycle_controller;
  logic       clk = 1'b0, reset_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0, Zero = 1'b0, mem_ready = 1'b0;
  logic       PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, instr_done, illegal_op;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_o;
  int vectors = 0, miscompares = 0;
  multicycle_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .instr_done(instr_done), .illegal_op(illegal_op), .state_o(state_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    check("rst_state", state_o, 0);
    check("rst_regwrite", RegWrite, 0);
    check("rst_memwrite", MemWrite, 0);
    check("rst_irwrite", IRWrite, 0);
    check("rst_pcwrite", PCWrite, 0);
    check("rst_done", instr_done, 0);
    check("rst_illegal", illegal_op, 0);
    step();
    check("rst_hold_state", state_o, 0);
    mem_ready = 1'b1;
    #1;
    check("rst_irwrite_mr", IRWrite, 1);
    check("rst_pcwrite_mr", PCWrite, 1);
    reset_n = 1'b1;
    op = 7'b0000011;
    #1;
    check("fetch_srcb", ALUSrcB, 2'b10);
    check("fetch_result", ResultSrc, 2'b10);
    step();
    check("lw_decode", state_o, 1);
    check("lw_decode_srca", ALUSrcA, 2'b01);
    check("lw_immsrc", ImmSrc, 2'b00);
    step();
    check("lw_memadr", state_o, 2);
    check("lw_memadr_srca", ALUSrcA, 2'b10);
    step();
    check("lw_memread", state_o, 3);
    check("lw_memread_adr", AdrSrc, 1);
    check("lw_memread_rw", RegWrite, 0);
    step();
    check("lw_memwb", state_o, 4);
    check("lw_memwb_rw", RegWrite, 1);
    check("lw_memwb_res", ResultSrc, 2'b01);
    check("lw_memwb_done", instr_done, 0);
    step();
    check("lw_fetch", state_o, 0);
    check("lw_done", instr_done, 1);
    check("lw_fetch_rw", RegWrite, 0);
    op = 7'b0100011;
    step();
    check("sw_decode", state_o, 1);
    check("sw_done_drop", instr_done, 0);
    check("sw_immsrc", ImmSrc, 2'b01);
    step();
    check("sw_memadr", state_o, 2);
    step();
    mem_ready = 1'b0;
    #1;
    check("sw_memwrite", state_o, 5);
    check("sw_mw1", MemWrite, 1);
    step();
    check("sw_stall1", state_o, 5);
    check("sw_mw2", MemWrite, 1);
    check("sw_stall_done", instr_done, 0);
    step();
    mem_ready = 1'b1;
    #1;
    check("sw_stall2", state_o, 5);
    check("sw_mw3", MemWrite, 1);
    step();
    check("sw_fetch", state_o, 0);
    check("sw_mw_drop", MemWrite, 0);
    check("sw_done", instr_done, 1);
    op = 7'b1100011; funct3 = 3'b000; Zero = 1'b1;
    step();
    check("beq_immsrc", ImmSrc, 2'b10);
    step();
    check("beq_state", state_o, 9);
    check("beq_pcw_z1", PCWrite, 1);
    check("beq_aluctl", ALUControl, 3'b001);
    step();
    check("beq_done", instr_done, 1);
    Zero = 1'b0;
    step();
    step();
    check("beq2_state", state_o, 9);
    check("beq_pcw_z0", PCWrite, 0);
    step();
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    step();
    step();
    check("r_state", state_o, 6);
    check("r_sub", ALUControl, 3'b001);
    check("r_srcb", ALUSrcB, 2'b00);
    step();
    check("r_aluwb", state_o, 8);
    check("r_aluwb_rw", RegWrite, 1);
    step();
    check("r_done", instr_done, 1);
    op = 7'b0010011;
    step();
    step();
    check("i_state", state_o, 7);
    check("i_addi", ALUControl, 3'b000);
    check("i_srcb", ALUSrcB, 2'b01);
    funct3 = 3'b010; #1;
    check("i_slt", ALUControl, 3'b101);
    funct3 = 3'b110; #1;
    check("i_or", ALUControl, 3'b011);
    funct3 = 3'b111; #1;
    check("i_and", ALUControl, 3'b010);
    funct3 = 3'b000;
    step();
    step();
    check("i_done", instr_done, 1);
    op = 7'b1101111;
    step();
    check("jal_immsrc", ImmSrc, 2'b11);
    step();
    check("jal_state", state_o, 10);
    check("jal_pcw", PCWrite, 1);
    check("jal_srca", ALUSrcA, 2'b01);
    step();
    check("jal_aluwb", state_o, 8);
    step();
    check("jal_done", instr_done, 1);
    op = 7'b1111111;
    step();
    check("ill_decode", state_o, 1);
    check("ill_early", illegal_op, 0);
    step();
    check("ill_fetch", state_o, 0);
    check("ill_pulse", illegal_op, 1);
    check("ill_nodone", instr_done, 0);
    op = 7'b0000011;
    step();
    check("ill_drop", illegal_op, 0);
    step();
    step();
    check("mid_memread", state_o, 3);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_state", state_o, 0);
    check("mid_rst_rw", RegWrite, 0);
    step();
    check("mid_rst_done", instr_done, 0);
    reset_n = 1'b1;
    step();
    check("post_rst_decode", state_o, 1);
    check("post_rst_done", instr_done, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
